stream_arb_mux: RTL and testbench
=================================

Name: stream_arb_mux

Overview:
- Parametrised M-input, N-bit multiplexer with valid/ready handshakes on every port and one registered output stage.
- Two selection modes, chosen per cycle:
  - fixed: the channel named by `sel` is used, as a plain mux would.
  - round-robin: fair arbitration across all channels with valid data.
- Used wherever several producers share one consumer, e.g. merging writeback or memory-request sources in the core datapath.

Parameters:
- N, 32, data width of each channel in bits.
- M, 4, number of input channels (≥2).
- S, $clog2(M), width of `sel` and `out_chan`.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_data  input  M*N  channel i occupies bits [i*N +: N].
- in_valid  input  M  per-channel valid.
- in_ready  output  M  per-channel ready; combinational.
- mode  input  1  0 = fixed select, 1 = round-robin.
- sel  input  S  channel index used in fixed mode.
- out_data  output  N  registered data.
- out_valid  output  1  registered valid.
- out_chan  output  S  index of the channel that produced out_data; registered.
- out_ready  input  1  downstream ready.

Behaviour:
- Reset, on the clk edge with rst=1:
  - out_valid=0, out_data=0, out_chan=0, round-robin pointer ptr=0.
  - rst has priority over every other event, including a transfer in progress.
  - in_ready is all-zero while rst=1.
- Output register state:
  - Empty: out_valid=0.
  - Full: out_valid=1.
  - Register may load this cycle: load_en = !out_valid | out_ready.
- Transfer rules:
  - Output transfer: out_valid & out_ready at the clock edge.
  - Input transfer on channel i: in_valid[i] & in_ready[i].
- Grant, combinational, at most one-hot:
  - mode=0: grant[sel] = in_valid[sel]. If sel ≥ M, no grant.
  - mode=1: the first i with in_valid[i]=1, searching ptr, ptr+1, …, M-1, 0, …, ptr-1 (wrap modulo M).
  - in_ready[i] = grant[i] & load_en & !rst.
- On the clock edge, when some channel k transfers:
  - out_data <= in_data[k], out_chan <= k, out_valid <= 1.
  - If mode=1: ptr <= (k+1) mod M. If mode=0: ptr unchanged.
- On the clock edge, when no input transfers:
  - If an output transfer occurs: out_valid <= 0.
  - Otherwise: out_data, out_valid and out_chan hold.
- Stability: while out_valid=1 and out_ready=0, out_data and out_chan do not change.
- Latency and throughput:
  - Latency is 1 cycle from input transfer to out_valid.
  - Throughput is 1 transfer per cycle. A simultaneous output transfer and new input transfer is allowed (back-to-back).
- in_ready does not depend on in_data. It may depend on in_valid, mode, sel, ptr, out_valid, out_ready and rst.
- Mode switching: a change of mode or sel takes effect in the same cycle's grant. No state beyond ptr persists.
- Channels with in_valid=0 are never granted, in either mode.
- Fairness: in round-robin mode, under continuous out_ready=1 and all M inputs valid, grants rotate 0, 1, …, M-1, 0, … with no channel starved.

Test Plan:
- Reset / idle:
  - Stimulus: rst=1 for 2 cycles with all in_valid=1, then rst=0, out_ready=1, in_valid=0.
  - Response: out_valid=0, out_data=0, out_chan=0, in_ready=0 throughout.
- Fixed select:
  - Stimulus: mode=0, sel=2, in_data channels = 0x11,0x22,0x33,0x44, all valid, out_ready=1.
  - Response: each cycle in_ready=4'b0100; the cycle after the first transfer, out_data=0x33, out_chan=2. With sel=2 but in_valid[2]=0, out_valid drops to 0 after draining.
- Round-robin rotation:
  - Stimulus: mode=1, all 4 channels valid, out_ready=1 for 8 cycles.
  - Response: out_chan sequence 0,1,2,3,0,1,2,3 on consecutive cycles; one output transfer per cycle.
- Round-robin skip and wrap:
  - Stimulus: mode=1, only in_valid[1] and in_valid[3] set.
  - Response: out_chan alternates 1,3,1,3. ptr wraps from 0 past 3 correctly.
- Backpressure:
  - Stimulus: out_valid=1 holding 0x22, out_ready=0 for 3 cycles with all inputs valid.
  - Response: in_ready=0 and out_data=0x22 stable for those cycles. On out_ready=1, the next grant loads in the same edge as the drain.
- Reset mid-stream and out-of-range sel:
  - Stimulus A: assert rst while out_valid=1, out_ready=0.
  - Response A: next cycle out_valid=0, ptr=0, and the first round-robin grant afterwards goes to channel 0.
  - Stimulus B: mode=0 with sel=M-1+1 (requires M<2^S, e.g. M=3).
  - Response B: no grant, in_ready all-zero.

Source files
------------

// File: rtl/stream_arb_mux_if.sv
// stream_arb_mux_if: valid/ready bundle for stream_arb_mux (M inputs of N bits, select controls, registered N-bit output)
interface stream_arb_mux_if #(
  parameter int N = 32,
  parameter int M = 4,
  parameter int S = $clog2(M)
);
  logic [M*N-1:0] in_data;
  logic [M-1:0]   in_valid;
  logic [M-1:0]   in_ready;
  logic           mode;
  logic [S-1:0]   sel;
  logic [N-1:0]   out_data;
  logic           out_valid;
  logic [S-1:0]   out_chan;
  logic           out_ready;
  modport slave (
    input  in_data, in_valid, mode, sel, out_ready,
    output in_ready, out_data, out_valid, out_chan
  );
  modport master (
    output in_data, in_valid, mode, sel, out_ready,
    input  in_ready, out_data, out_valid, out_chan
  );
endinterface

// File: rtl/stream_arb_mux.sv
// stream_arb_mux: M-to-1 valid/ready mux (fixed sel or round-robin), ports clk, rst, bus (in_* / out_* / mode / sel) with one registered output stage
module stream_arb_mux #(
  parameter int N = 32,
  parameter int M = 4,
  parameter int S = $clog2(M)
) (
  input logic clk,
  input logic rst,
  stream_arb_mux_if.slave bus
);
  logic [S-1:0] ptr;
  logic [S-1:0] idx;
  logic [S-1:0] k;
  logic [M-1:0] grant;
  logic         found;
  logic         load_en;
  assign load_en = !bus.out_valid | bus.out_ready;
  assign bus.in_ready = grant & {M{load_en & !rst}};
  always_comb begin
    grant = '0;
    idx = '0;
    found = 1'b0;
    k = '0;
    if (!bus.mode) begin
      if (int'(bus.sel) < M) grant[bus.sel] = bus.in_valid[bus.sel];
    end else begin
      for (int j = 0; j < M; j++) begin
        idx = S'((int'(ptr) + j) % M);
        if (!found && bus.in_valid[idx]) begin
          grant[idx] = 1'b1;
          found = 1'b1;
        end
      end
    end
    for (int j = 0; j < M; j++) if (grant[j]) k = S'(j);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.out_data <= '0;
      bus.out_chan <= '0;
      ptr <= '0;
    end else if (|bus.in_ready) begin
      bus.out_valid <= 1'b1;
      bus.out_data <= bus.in_data[k*N +: N];
      bus.out_chan <= k;
      if (bus.mode) ptr <= (k == S'(M-1)) ? '0 : k + 1'b1;
    end else if (bus.out_valid && bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_stream_arb_mux.sv
// tb_stream_arb_mux: directed self-checking bench for stream_arb_mux (M=4/N=32 main instance, M=3/N=8 for out-of-range sel)
module tb_stream_arb_mux;
  logic clk = 1'b0;
  logic rst;
  int n_cmp = 0;
  int n_bad = 0;
  always #5 clk = ~clk;
  stream_arb_mux_if #(.N(32), .M(4)) a ();
  stream_arb_mux_if #(.N(8), .M(3)) b ();
  stream_arb_mux #(.N(32), .M(4)) dut_a (.clk(clk), .rst(rst), .bus(a.slave));
  stream_arb_mux #(.N(8), .M(3)) dut_b (.clk(clk), .rst(rst), .bus(b.slave));
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    a.in_data = {32'h44, 32'h33, 32'h22, 32'h11};
    a.in_valid = 4'b1111;
    a.mode = 1'b1;
    a.sel = 2'd0;
    a.out_ready = 1'b1;
    b.in_data = {8'hc3, 8'hb2, 8'ha1};
    b.in_valid = 3'b000;
    b.mode = 1'b0;
    b.sel = 2'd0;
    b.out_ready = 1'b1;
    #1;
    n_cmp++;
    if (a.in_ready !== 4'b0000) begin n_bad++; $display("FAIL reset_ready_pre got %b want 0000", a.in_ready); end
    tick();
    tick();
    n_cmp++;
    if (a.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b want 0", a.out_valid); end
    n_cmp++;
    if (a.out_data !== 32'h0) begin n_bad++; $display("FAIL reset_data got %h want 0", a.out_data); end
    n_cmp++;
    if (a.out_chan !== 2'd0) begin n_bad++; $display("FAIL reset_chan got %0d want 0", a.out_chan); end
    n_cmp++;
    if (a.in_ready !== 4'b0000) begin n_bad++; $display("FAIL reset_ready got %b want 0000", a.in_ready); end
    rst = 1'b0;
    a.in_valid = 4'b0000;
    @(negedge clk);
    n_cmp++;
    if (a.in_ready !== 4'b0000) begin n_bad++; $display("FAIL idle_ready got %b want 0000", a.in_ready); end
    tick();
    n_cmp++;
    if (a.out_valid !== 1'b0) begin n_bad++; $display("FAIL idle_valid got %b want 0", a.out_valid); end
  endtask
  task automatic test_fixed();
    a.mode = 1'b0;
    a.sel = 2'd2;
    a.in_valid = 4'b1111;
    a.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if (a.in_ready !== 4'b0100) begin n_bad++; $display("FAIL fixed_ready[%0d] got %b want 0100", i, a.in_ready); end
      tick();
      n_cmp++;
      if (a.out_valid !== 1'b1 || a.out_data !== 32'h33 || a.out_chan !== 2'd2) begin
        n_bad++; $display("FAIL fixed_out[%0d] got v%b %h ch%0d want v1 33 ch2", i, a.out_valid, a.out_data, a.out_chan);
      end
    end
    a.in_valid = 4'b1011;
    @(negedge clk);
    n_cmp++;
    if (a.in_ready !== 4'b0000) begin n_bad++; $display("FAIL fixed_novalid_ready got %b want 0000", a.in_ready); end
    tick();
    n_cmp++;
    if (a.out_valid !== 1'b0) begin n_bad++; $display("FAIL fixed_drain got %b want 0", a.out_valid); end
  endtask
  task automatic test_round_robin();
    logic [31:0] exp_d [4] = '{32'h11, 32'h22, 32'h33, 32'h44};
    a.mode = 1'b1;
    a.in_valid = 4'b1111;
    a.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n_cmp++;
      if (a.in_ready !== 4'(1 << (i % 4))) begin n_bad++; $display("FAIL rr_ready[%0d] got %b want %b", i, a.in_ready, 4'(1 << (i % 4))); end
      tick();
      n_cmp++;
      if (a.out_valid !== 1'b1 || a.out_chan !== 2'(i % 4) || a.out_data !== exp_d[i % 4]) begin
        n_bad++; $display("FAIL rr_out[%0d] got v%b ch%0d %h want v1 ch%0d %h", i, a.out_valid, a.out_chan, a.out_data, i % 4, exp_d[i % 4]);
      end
    end
  endtask
  task automatic test_skip_wrap();
    logic [1:0] exp_c [4] = '{2'd1, 2'd3, 2'd1, 2'd3};
    a.mode = 1'b1;
    a.in_valid = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++;
      if (a.out_valid !== 1'b1 || a.out_chan !== exp_c[i]) begin
        n_bad++; $display("FAIL skip_out[%0d] got v%b ch%0d want v1 ch%0d", i, a.out_valid, a.out_chan, exp_c[i]);
      end
    end
  endtask
  task automatic test_backpressure();
    a.mode = 1'b0;
    a.sel = 2'd1;
    a.in_valid = 4'b1111;
    a.out_ready = 1'b1;
    tick();
    a.mode = 1'b1;
    a.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if (a.in_ready !== 4'b0000) begin n_bad++; $display("FAIL bp_ready[%0d] got %b want 0000", i, a.in_ready); end
      tick();
      n_cmp++;
      if (a.out_valid !== 1'b1 || a.out_data !== 32'h22 || a.out_chan !== 2'd1) begin
        n_bad++; $display("FAIL bp_hold[%0d] got v%b %h ch%0d want v1 22 ch1", i, a.out_valid, a.out_data, a.out_chan);
      end
    end
    a.out_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (a.in_ready !== 4'b0001) begin n_bad++; $display("FAIL bp_release_ready got %b want 0001", a.in_ready); end
    tick();
    n_cmp++;
    if (a.out_valid !== 1'b1 || a.out_data !== 32'h11 || a.out_chan !== 2'd0) begin
      n_bad++; $display("FAIL bp_release_out got v%b %h ch%0d want v1 11 ch0", a.out_valid, a.out_data, a.out_chan);
    end
  endtask
  task automatic test_reset_midstream();
    a.out_ready = 1'b0;
    rst = 1'b1;
    #1;
    n_cmp++;
    if (a.in_ready !== 4'b0000) begin n_bad++; $display("FAIL mid_rst_ready got %b want 0000", a.in_ready); end
    tick();
    rst = 1'b0;
    n_cmp++;
    if (a.out_valid !== 1'b0 || a.out_data !== 32'h0 || a.out_chan !== 2'd0) begin
      n_bad++; $display("FAIL mid_rst_out got v%b %h ch%0d want v0 0 ch0", a.out_valid, a.out_data, a.out_chan);
    end
    a.mode = 1'b1;
    a.in_valid = 4'b1111;
    a.out_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (a.in_ready !== 4'b0001) begin n_bad++; $display("FAIL mid_rst_ptr got %b want 0001", a.in_ready); end
    tick();
    n_cmp++;
    if (a.out_chan !== 2'd0 || a.out_data !== 32'h11) begin
      n_bad++; $display("FAIL mid_rst_first got ch%0d %h want ch0 11", a.out_chan, a.out_data);
    end
  endtask
  task automatic test_oob_sel();
    b.mode = 1'b0;
    b.sel = 2'd3;
    b.in_valid = 3'b111;
    b.out_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (b.in_ready !== 3'b000) begin n_bad++; $display("FAIL oob_ready got %b want 000", b.in_ready); end
    tick();
    n_cmp++;
    if (b.out_valid !== 1'b0) begin n_bad++; $display("FAIL oob_valid got %b want 0", b.out_valid); end
    b.sel = 2'd2;
    @(negedge clk);
    n_cmp++;
    if (b.in_ready !== 3'b100) begin n_bad++; $display("FAIL sel2_ready got %b want 100", b.in_ready); end
    tick();
    n_cmp++;
    if (b.out_valid !== 1'b1 || b.out_data !== 8'hc3 || b.out_chan !== 2'd2) begin
      n_bad++; $display("FAIL sel2_out got v%b %h ch%0d want v1 c3 ch2", b.out_valid, b.out_data, b.out_chan);
    end
  endtask
  initial begin
    test_reset();
    test_fixed();
    test_round_robin();
    test_skip_wrap();
    test_backpressure();
    test_reset_midstream();
    test_oob_sel();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
